dpram_stream_reader: RTL

Read-side engine for the on-chip dual-port RAM (`dprams`): on a start command it fetches `len` consecutive words beginning at `base_addr`, hides the RAM's one-cycle read latency, and presents them as a valid/ready stream with a last-beat marker. It sits on the RAM's read port (`rdaddress`/`q`), opposite the write-side logic that fills the buffer, and feeds downstream consumers (UART TX, display, checksum logic) that may apply backpressure.

---
 rtl/dpram_pkg.sv | 15 +
 rtl/dpram_rd_fifo.sv | 75 +++++++
 rtl/dpram_stream_reader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/dpram_pkg.sv
// Shared types and sizing for the dual-port RAM read-side stream engine.
package dpram_pkg;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned FIFO_CNT_W = FIFO_PTR_W + 1;
    localparam int unsigned CSUM_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/dpram_rd_fifo.sv
// Small show-ahead FIFO of {last, data} that absorbs RAM read latency and stream backpressure.
module dpram_rd_fifo
    import dpram_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_W-1:0]     push_data_i,
    input  logic                  push_last_i,
    input  logic                  pop_i,
    output logic [DATA_W-1:0]     head_data_o,
    output logic                  head_last_o,
    output logic                  valid_o,
    output logic [FIFO_CNT_W-1:0] count_o
);

    localparam int unsigned ENTRY_W = DATA_W + 1;

    logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_CNT_W-1:0] cnt_q, cnt_d;
    logic                  do_push;
    logic                  do_pop;

    // Guard against misuse so pointers never corrupt on overflow/underflow.
    assign do_push = push_i && (cnt_q != FIFO_CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop_i && (cnt_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + FIFO_PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + FIFO_CNT_W'(1);
            2'b01:   cnt_d = cnt_q - FIFO_CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
            end
        end
    end

    assign head_data_o = mem_q[rd_ptr_q][DATA_W-1:0];
    assign head_last_o = mem_q[rd_ptr_q][DATA_W];
    assign valid_o     = (cnt_q != '0);
    assign count_o     = cnt_q;

    no_overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && (cnt_q == FIFO_CNT_W'(FIFO_DEPTH)) && !pop_i));

endmodule

// File: rtl/dpram_stream_reader.sv
// Fetches len words from the dual-port RAM read port and streams them out with valid/ready/last.
// Optional running checksum of sent words is built when DPRAM_RD_CHECKSUM_EN is defined.
module dpram_stream_reader
    import dpram_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic [CSUM_W-1:0] checksum
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned OCC_W = FIFO_CNT_W + 1;

    rd_state_t             state_q, state_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic                  rd_en_q, rd_en_d;
    logic                  rd_last_q, rd_last_d;
    logic                  pend_q;
    logic                  pend_last_q;
    logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [FIFO_CNT_W-1:0] fifo_cnt;
    logic [DATA_W-1:0]     fifo_data;
    logic                  fifo_last;
    logic                  fifo_valid;
    logic                  beat;
    logic [OCC_W-1:0]      occ;
    logic                  space_ok;

    assign beat = fifo_valid && m_ready;

    // Entries that will be committed once everything in flight lands, net of this cycle's pop.
    assign occ      = OCC_W'(fifo_cnt) + OCC_W'(pend_q) + OCC_W'(rd_en_q) - OCC_W'(beat);
    assign space_ok = (occ < OCC_W'(FIFO_DEPTH));

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        rd_en_d     = 1'b0;
        rd_last_d   = 1'b0;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat ? (beat_cnt_q - CNT_W'(1)) : beat_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d     = (len == CNT_W'(1)) ? DRAIN : FETCH;
                        rd_addr_d   = base_addr;
                        rd_en_d     = 1'b1;
                        rd_last_d   = (len == CNT_W'(1));
                        issue_cnt_d = len - CNT_W'(1);
                        beat_cnt_d  = len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (space_ok) begin
                    rd_addr_d   = rd_addr_q + ADDR_W'(1);
                    rd_en_d     = 1'b1;
                    rd_last_d   = (issue_cnt_q == CNT_W'(1));
                    issue_cnt_d = issue_cnt_q - CNT_W'(1);
                    if (issue_cnt_q == CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (beat && (beat_cnt_q == CNT_W'(1))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_last_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            rd_en_q     <= rd_en_d;
            rd_last_q   <= rd_last_d;
            pend_q      <= rd_en_q;
            pend_last_q <= rd_last_q;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // RAM data lands one cycle after the fetch, tagged with the last flag of that fetch.
    dpram_rd_fifo #(
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (pend_q),
        .push_data_i(ram_q),
        .push_last_i(pend_last_q),
        .pop_i      (beat),
        .head_data_o(fifo_data),
        .head_last_o(fifo_last),
        .valid_o    (fifo_valid),
        .count_o    (fifo_cnt)
    );

`ifdef DPRAM_RD_CHECKSUM_EN
    logic [CSUM_W-1:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            csum_q <= '0;
        end else if (beat) begin
            csum_q <= csum_q + CSUM_W'(fifo_data);
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    assign rd_addr = rd_addr_q;
    assign rd_en   = rd_en_q;
    assign m_data  = fifo_data;
    assign m_valid = fifo_valid;
    assign m_last  = fifo_last;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
